// File: rtl/result_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : result_arbiter
// Purpose  : Shares the single result FIFO write port between N_SRC result
//            producers (0 = DDS, 1 = SPI, 2 = loop-back). Each producer owns a
//            small circular buffer so single-cycle strobes are never lost
//            while another source is writing. A round-robin scheduler drains
//            the buffers into one registered output stage that honours the
//            result FIFO full flag. Drops are flagged per source.
// Ports    : clock_i        system clock (rising edge)
//            resetn_i       asynchronous active-low reset
//            src_wr_en_i    per-source write strobe
//            src_data_i     source i word at [i*DATA_WIDTH +: DATA_WIDTH]
//            fifo_full_i    result FIFO full
//            clear_i        synchronous clear of overflow / drop counter
//            result_data_o  word to result FIFO
//            result_wr_en_o write strobe to result FIFO
//            overflow_o     sticky per-source drop flags
//            busy_o         any buffer non-empty or output stage valid
//            drop_count_o   saturating dropped-word total (optional)
// Options  : RESULT_ARB_DROP_COUNT_EN - adds drop_count_o and its counter
// Revision : 1.0 - initial release
// ============================================================================
module result_arbiter #(
  parameter int N_SRC      = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clock_i,
  input  logic                        resetn_i,
  input  logic [N_SRC-1:0]            src_wr_en_i,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_data_i,
  input  logic                        fifo_full_i,
  input  logic                        clear_i,
  output logic [DATA_WIDTH-1:0]       result_data_o,
  output logic                        result_wr_en_o,
  output logic [N_SRC-1:0]            overflow_o,
  output logic                        busy_o
`ifdef RESULT_ARB_DROP_COUNT_EN
  ,
  output logic [15:0]                 drop_count_o
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RRW = $clog2(N_SRC);

  // Returns (base + off) mod N_SRC; off is always < N_SRC so one
  // conditional subtraction is enough.
  function automatic logic [RRW-1:0] rr_index(input logic [RRW-1:0] base,
                                              input int unsigned   off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= N_SRC) s = s - N_SRC;
    return s[RRW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Per-source status / control
  // --------------------------------------------------------------------------
  logic [N_SRC-1:0]      w_empty;
  logic [N_SRC-1:0]      w_full;
  logic [N_SRC-1:0]      w_push;
  logic [N_SRC-1:0]      w_pop;
  logic [N_SRC-1:0]      w_drop;
  logic [DATA_WIDTH-1:0] w_head [N_SRC];

  // Output stage and scheduler state
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [RRW-1:0]        rr_ptr_q,    rr_ptr_d;
  logic [N_SRC-1:0]      overflow_q,  overflow_d;

  logic                  w_load;
  logic                  w_grant_vld;
  logic [RRW-1:0]        w_grant_idx;

  // --------------------------------------------------------------------------
  // Source buffers
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;

    assign w_empty[i] = (wptr_q == rptr_q);
    assign w_full[i]  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign w_head[i]  = mem_q[rptr_q[AW-1:0]];

    // A full buffer still accepts a word when its head leaves this cycle:
    // the new word lands in the slot being vacated.
    assign w_push[i] = src_wr_en_i[i] & (~w_full[i] | w_pop[i]);
    assign w_drop[i] = src_wr_en_i[i] &  w_full[i] & ~w_pop[i];

    assign wptr_d = wptr_q + {{AW{1'b0}}, w_push[i]};
    assign rptr_d = rptr_q + {{AW{1'b0}}, w_pop[i]};

    // Storage needs no reset: contents are only read when the pointers
    // say the entry is valid.
    always_ff @(posedge clock_i) begin
      if (w_push[i]) begin
        mem_q[wptr_q[AW-1:0]] <= src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin scheduler
  // --------------------------------------------------------------------------
  assign result_wr_en_o = out_valid_q & ~fifo_full_i;
  // Stage may take a new word when empty or when its word leaves this cycle.
  assign w_load         = ~out_valid_q | result_wr_en_o;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!w_grant_vld && !w_empty[rr_index(rr_ptr_q, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = rr_index(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    w_pop       = '0;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (w_load) begin
      if (w_grant_vld) begin
        w_pop[w_grant_idx] = 1'b1;
        rr_ptr_d           = rr_index(w_grant_idx, 1);
        out_valid_d        = 1'b1;
        out_data_d         = w_head[w_grant_idx];
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Sticky flags; a drop coinciding with clear still sets its flag.
  always_comb begin
    if (clear_i) overflow_d = w_drop;
    else         overflow_d = overflow_q | w_drop;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      overflow_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result_data_o = out_data_q;
  assign overflow_o    = overflow_q;
  assign busy_o        = out_valid_q | ~(&w_empty);

  // --------------------------------------------------------------------------
  // Optional saturating drop counter
  // --------------------------------------------------------------------------
`ifdef RESULT_ARB_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [3:0]  w_drop_n;
  logic [16:0] w_cnt_sum;

  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_drop_n = w_drop_n + {3'b000, w_drop[i]};
    end
  end

  assign w_cnt_sum = {1'b0, drop_cnt_q} + {13'b0, w_drop_n};

  always_comb begin
    if (clear_i)           drop_cnt_d = {12'b0, w_drop_n};
    else if (w_cnt_sum[16]) drop_cnt_d = 16'hFFFF;
    else                   drop_cnt_d = w_cnt_sum[15:0];
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) drop_cnt_q <= '0;
    else           drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_arbiter
// Purpose  : Directed self-checking bench for result_arbiter (N_SRC=3,
//            DATA_WIDTH=32, DEPTH=4). Drop-counter checks are compiled in
//            only when RESULT_ARB_DROP_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_arbiter;

  localparam int N_SRC = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_SRC-1:0]  wr_en;
  logic [N_SRC*DW-1:0] data;
  logic              full;
  logic              clr;
  logic [DW-1:0]     res_data;
  logic              res_wr;
  logic [N_SRC-1:0]  ovf;
  logic              busy;
`ifdef RESULT_ARB_DROP_COUNT_EN
  logic [15:0]       dcnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_arbiter #(
    .N_SRC      (N_SRC),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock_i        (clk),
    .resetn_i       (rst_n),
    .src_wr_en_i    (wr_en),
    .src_data_i     (data),
    .fifo_full_i    (full),
    .clear_i        (clr),
    .result_data_o  (res_data),
    .result_wr_en_o (res_wr),
    .overflow_o     (ovf),
    .busy_o         (busy)
`ifdef RESULT_ARB_DROP_COUNT_EN
    ,
    .drop_count_o   (dcnt)
`endif
  );

  // Advance to 1 ns after the next rising edge: outputs settled, inputs
  // driven here are seen at the following edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    wr_en = '0;
    data  = '0;
    full  = 1'b0;
    clr   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    checks++; if (res_wr !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", res_wr); end
    checks++; if (res_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", res_data); end
    checks++; if (ovf !== 3'b000) begin failures++; $display("FAIL reset_overflow: got %b expected 000", ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef RESULT_ARB_DROP_COUNT_EN
    checks++; if (dcnt !== 16'd0) begin failures++; $display("FAIL reset_drop_count: got %0d expected 0", dcnt); end
`endif
  endtask

  // One strobe on src1; write appears two cycles later, then idle.
  task automatic test_single;
    repeat (6) tick();
    wr_en = 3'b010;
    data  = {32'h0, 32'h12345678, 32'h0};
    tick();
    wr_en = '0;
    checks++; if (res_wr !== 1'b0) begin failures++; $display("FAIL single_c1_wr_en: got %b expected 0", res_wr); end
    tick();
    checks++; if (res_wr !== 1'b1 || res_data !== 32'h12345678) begin failures++; $display("FAIL single_c2_write: got wr=%b data=%h expected wr=1 data=12345678", res_wr, res_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_c2_busy: got %b expected 1", busy); end
    tick();
    checks++; if (res_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_c3_idle: got wr=%b busy=%b expected 0 0", res_wr, busy); end
  endtask

  // After the src1 grant rr_ptr is 2, so a full burst starts at src2.
  task automatic test_rr_wrap;
    logic [DW-1:0] exp [3];
    exp[0] = 32'hC0; exp[1] = 32'hA0; exp[2] = 32'hB0;
    wr_en = 3'b111;
    data  = {32'hC0, 32'hB0, 32'hA0};
    tick();
    wr_en = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (res_wr !== 1'b1 || res_data !== exp[k]) begin failures++; $display("FAIL rr_wrap_word%0d: got wr=%b data=%h expected wr=1 data=%h", k, res_wr, res_data, exp[k]); end
      tick();
    end
    checks++; if (res_wr !== 1'b0) begin failures++; $display("FAIL rr_wrap_end: got %b expected 0", res_wr); end
  endtask

  // From reset (rr_ptr 0): two bursts, each emitted 0xA0, 0xB0, 0xC0 back to back.
  task automatic test_back_to_back;
    logic [DW-1:0] exp [3];
    exp[0] = 32'hA0; exp[1] = 32'hB0; exp[2] = 32'hC0;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      wr_en = 3'b111;
      data  = {32'hC0, 32'hB0, 32'hA0};
      tick();
      wr_en = '0;
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++; if (res_wr !== 1'b1 || res_data !== exp[k]) begin failures++; $display("FAIL burst%0d_word%0d: got wr=%b data=%h expected wr=1 data=%h", rep, k, res_wr, res_data, exp[k]); end
        tick();
      end
      checks++; if (res_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL burst%0d_idle: got wr=%b busy=%b expected 0 0", rep, res_wr, busy); end
    end
  endtask

  // fifo_full held, 6 strobes on src0: 1 staged + 4 buffered, 1 dropped.
  task automatic test_overflow;
    full = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wr_en = 3'b001;
      data  = {64'h0, 32'(32'h100 + n)};
      tick();
    end
    wr_en = '0;
    checks++; if (ovf !== 3'b001) begin failures++; $display("FAIL ovf_flag: got %b expected 001", ovf); end
`ifdef RESULT_ARB_DROP_COUNT_EN
    checks++; if (dcnt !== 16'd1) begin failures++; $display("FAIL ovf_drop_count: got %0d expected 1", dcnt); end
`endif
    checks++; if (res_wr !== 1'b0 || res_data !== 32'h100 || busy !== 1'b1) begin failures++; $display("FAIL ovf_hold: got wr=%b data=%h busy=%b expected 0 100 1", res_wr, res_data, busy); end
    tick();
    checks++; if (res_wr !== 1'b0 || res_data !== 32'h100) begin failures++; $display("FAIL ovf_hold2: got wr=%b data=%h expected 0 100", res_wr, res_data); end
    full = 1'b0;
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++; if (res_wr !== 1'b1 || res_data !== 32'(32'h100 + n)) begin failures++; $display("FAIL ovf_drain%0d: got wr=%b data=%h expected wr=1 data=%h", n, res_wr, res_data, 32'(32'h100 + n)); end
      tick();
    end
    checks++; if (res_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ovf_drain_end: got wr=%b busy=%b expected 0 0", res_wr, busy); end
  endtask

  // src2 buffer full; release fifo_full while pushing src2: pop+push, no drop.
  task automatic test_pop_push;
    full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wr_en = 3'b100;
      data  = {32'(32'h200 + n), 64'h0};
      tick();
    end
    full  = 1'b0;
    wr_en = 3'b100;
    data  = {32'h205, 64'h0};
    #1;
    checks++; if (res_wr !== 1'b1 || res_data !== 32'h200) begin failures++; $display("FAIL pp_first: got wr=%b data=%h expected wr=1 data=200", res_wr, res_data); end
    tick();
    wr_en = '0;
    for (int n = 1; n < 6; n++) begin
      checks++; if (res_wr !== 1'b1 || res_data !== 32'(32'h200 + n)) begin failures++; $display("FAIL pp_word%0d: got wr=%b data=%h expected wr=1 data=%h", n, res_wr, res_data, 32'(32'h200 + n)); end
      tick();
    end
    checks++; if (res_wr !== 1'b0) begin failures++; $display("FAIL pp_end: got %b expected 0", res_wr); end
    checks++; if (ovf !== 3'b001) begin failures++; $display("FAIL pp_overflow: got %b expected 001", ovf); end
`ifdef RESULT_ARB_DROP_COUNT_EN
    checks++; if (dcnt !== 16'd1) begin failures++; $display("FAIL pp_drop_count: got %0d expected 1", dcnt); end
`endif
  endtask

  // clear coincident with a src1 drop, then clear alone.
  task automatic test_clear;
    full = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n == 5) begin
        checks++; if (ovf !== 3'b001) begin failures++; $display("FAIL clr_sticky: got %b expected 001", ovf); end
      end
      wr_en = 3'b010;
      data  = {32'h0, 32'(32'h300 + n), 32'h0};
      clr   = (n == 5);
      tick();
    end
    wr_en = '0;
    clr   = 1'b0;
    checks++; if (ovf !== 3'b010) begin failures++; $display("FAIL clr_with_drop: got %b expected 010", ovf); end
`ifdef RESULT_ARB_DROP_COUNT_EN
    checks++; if (dcnt !== 16'd1) begin failures++; $display("FAIL clr_with_drop_count: got %0d expected 1", dcnt); end
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (ovf !== 3'b000) begin failures++; $display("FAIL clr_alone: got %b expected 000", ovf); end
`ifdef RESULT_ARB_DROP_COUNT_EN
    checks++; if (dcnt !== 16'd0) begin failures++; $display("FAIL clr_alone_count: got %0d expected 0", dcnt); end
`endif
    full = 1'b0;
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++; if (res_wr !== 1'b1 || res_data !== 32'(32'h300 + n)) begin failures++; $display("FAIL clr_drain%0d: got wr=%b data=%h expected wr=1 data=%h", n, res_wr, res_data, 32'(32'h300 + n)); end
      tick();
    end
    checks++; if (res_wr !== 1'b0) begin failures++; $display("FAIL clr_drain_end: got %b expected 0", res_wr); end
  endtask

  // Reset while words are held behind fifo_full: nothing stale ever emitted.
  task automatic test_reset_mid;
    full  = 1'b1;
    wr_en = 3'b111;
    data  = {32'hC0, 32'hB0, 32'hA0};
    tick();
    wr_en = '0;
    tick();
    checks++; if (busy !== 1'b1 || res_wr !== 1'b0) begin failures++; $display("FAIL rm_pre: got busy=%b wr=%b expected 1 0", busy, res_wr); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (res_wr !== 1'b0 || busy !== 1'b0 || res_data !== 32'h0 || ovf !== 3'b000) begin failures++; $display("FAIL rm_async: got wr=%b busy=%b data=%h ovf=%b expected 0 0 0 000", res_wr, busy, res_data, ovf); end
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    full  = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++; if (res_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rm_stale%0d: got wr=%b busy=%b expected 0 0", n, res_wr, busy); end
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single();
    test_rr_wrap();
    test_back_to_back();
    test_overflow();
    test_pop_push();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_arbiter.md
# result_arbiter

Shares the single 32-bit result FIFO write port between the pulse controller's result producers (DDS controller, SPI controller, loop-back path), replacing the OR/priority mux at the top of the timing controller. Each requester gets a small private buffer so single-cycle result strobes are never lost while another source is writing. A round-robin scheduler drains the buffers into one registered output stage that honours the result FIFO's full flag. Overflows are flagged per source.

## Interface
- N_SRC, 3, number of requesters (index 0 = DDS, 1 = SPI, 2 = loop-back), 2..8
- DATA_WIDTH, 32, result word width
- DEPTH, 4, entries per source buffer, power of two, 2..16
- clock  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- src_wr_en  in  N_SRC  per-source write strobe, one word per high cycle
- src_data  in  N_SRC*DATA_WIDTH  source i data at bits [i*DATA_WIDTH +: DATA_WIDTH], valid only while its strobe is high
- fifo_full  in  1  result FIFO full
- clear  in  1  synchronous clear of overflow and drop_count
- result_data  out  DATA_WIDTH  word to result FIFO
- result_wr_en  out  1  write strobe to result FIFO
- overflow  out  N_SRC  sticky per-source drop flag
- busy  out  1  any buffer non-empty or output stage valid
- drop_count  out  16  saturating total dropped words (only with RESULT_ARB_DROP_COUNT_EN)

## Operation
- Per source: circular buffer, DEPTH entries, read/write pointers one bit wider than log2(DEPTH); full/empty from pointer compare; pointers wrap naturally.
- Push: src_wr_en[i] high and buffer i not full -> word stored. If full -> word dropped, overflow[i] <= 1. Push into a full buffer in the same cycle that buffer is popped is accepted (occupancy stays DEPTH, no drop).
- Output stage: one register (out_valid, out_data). result_wr_en = out_valid & ~fifo_full (combinational); result_data = out_data.
- Load: when out_valid is 0 or the stage is being consumed this cycle, the scheduler picks a non-empty buffer, pops its head into the output stage and sets out_valid; if no buffer non-empty, out_valid <= 0 (when consumed).
- Round robin: search starts at rr_ptr, wraps modulo N_SRC; after a grant to source g, rr_ptr <= (g+1) mod N_SRC. No grant -> rr_ptr unchanged.
- fifo_full high: output stage holds word and valid; no new load; buffers keep accepting until individually full.
- clear: overflow <= 0, drop_count <= 0; a drop in the same cycle as clear wins (overflow bit set, count reflects only that cycle's drops).
- busy = out_valid | any buffer non-empty.

## Timing
- Reset values: result_wr_en 0, result_data 0, overflow 0, busy 0, drop_count 0, rr_ptr 0, all buffers empty, out_valid 0.
- Reset mid-operation: buffered and staged words discarded; no partial write emitted after resetn falls.
- Latency: strobe in cycle c -> result_wr_en earliest in cycle c+2 (buffer write at end of c, output load at end of c+1).
- Throughput: one word per cycle sustained while fifo_full low.
- Simultaneous strobes from all N_SRC sources in one cycle: all buffered; emitted in round-robin order starting at rr_ptr.
- Hold: out_data and result_wr_en stable while fifo_full high; word emitted in first cycle fifo_full is low.

## Configuration
- RESULT_ARB_DROP_COUNT_EN defined: drop_count port and counter present; +k per cycle where k = number of sources dropping that cycle, saturating at 16'hFFFF.
- Not defined: drop_count port and counter absent; overflow flags unchanged.

## Test plan
- Reset, single strobe src1 data 0x12345678 at cycle 10 -> result_wr_en high exactly at cycle 12 with 0x12345678, busy low from cycle 13.
- All three strobes same cycle, data 0xA0/0xB0/0xC0, rr_ptr 0 -> writes 0xA0, 0xB0, 0xC0 on consecutive cycles; then a second simultaneous burst -> order 0xA0, 0xB0, 0xC0 again (rr_ptr back at 0).
- fifo_full held high, src0 strobed 6 times (DEPTH 4) -> 4 buffered + 1 staged, 1 drop: overflow = 3'b001, drop_count = 1; release full -> exactly 5 words in order.
- Buffer full, same-cycle pop and push on src2 -> no drop, overflow[2] stays 0, word order preserved.
- clear coincident with a src1 drop -> overflow = 3'b010, drop_count = 1; clear alone next cycle -> both 0.
- resetn low while 3 words buffered and fifo_full high -> result_wr_en stays 0, busy 0 after reset, no stale word emitted once fifo_full drops.
